mem_access_unit: RTL

//   Load/store unit sitting after the ALU in the MEM stage: accepts a load/store op code

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-bus signals of the load/store unit
//   req_*   : op request from the pipeline (valid/ready handshake)
//   rsp_*   : one-cycle result strobe with load data and error flags
//   mem_*   : word-addressed data bus with byte write enables and ack
//   slave   : view of the load/store unit itself
//   master  : view of whoever drives requests and models the memory
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        addr_err;
  logic        bus_err;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, addr_err, bus_err,
           mem_en, mem_wen, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, addr_err, bus_err,
           mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a word bus with byte lanes
//   clk, resetn : clock and asynchronous active-low reset
//   bus         : mem_access_unit_if.slave (request in, response out, data bus out)
//   TIMEOUT_CYCLES : bus cycles without ack before the access ends with bus_err
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic resetn,
  mem_access_unit_if.slave bus
);
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;
  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [7:0] op_q, cnt, op;
  logic [1:0] a_q, a;
  logic [31:0] d, rdata_q, addr_q, wdata_q, wdata_n, ld_v;
  logic [3:0] wen_q, wen_n;
  logic [15:0] h;
  logic [7:0] b;
  logic ae_q, be_q, accept, half, word, known, misal, go_bus, ack, tout;
  always_comb begin
    op = bus.req_op;
    a = bus.req_addr[1:0];
    d = bus.req_wdata;
    half = op == LH || op == LHU || op == SH;
    word = op == LW || op == SW;
    known = half || word || op == LB || op == LBU || op == SB;
    misal = (half && a[0]) || (word && a != 2'b00);
    accept = state == IDLE && bus.req_valid;
    go_bus = known && !misal;
    wen_n = op == SB ? 4'b0001 << a : op == SH ? (a[1] ? 4'b1100 : 4'b0011) : op == SW ? 4'b1111 : 4'b0000;
    wdata_n = op == SB ? {4{d[7:0]}} : op == SH ? {2{d[15:0]}} : op == SW ? d : 32'h0;
    // lane select uses the byte offset captured at accept, not the live request
    b = bus.mem_rdata[{a_q, 3'b000} +: 8];
    h = bus.mem_rdata[{a_q[1], 4'b0000} +: 16];
    ld_v = op_q == LB ? {{24{b[7]}}, b} : op_q == LBU ? {24'h0, b} :
           op_q == LH ? {{16{h[15]}}, h} : op_q == LHU ? {16'h0, h} :
           op_q == LW ? bus.mem_rdata : 32'h0;
    ack = state == BUS && bus.mem_ack;
    // ack in the final counted cycle takes priority over the timeout
    tout = state == BUS && !bus.mem_ack && cnt == TMAX;
    state_n = state == IDLE ? (accept ? (go_bus ? BUS : RESP) : IDLE) :
              state == BUS ? ((ack || tout) ? RESP : BUS) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      op_q <= 8'h0;
      a_q <= 2'b00;
      cnt <= 8'h0;
      rdata_q <= 32'h0;
      ae_q <= 1'b0;
      be_q <= 1'b0;
      wen_q <= 4'h0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      op_q <= op;
      a_q <= a;
      cnt <= 8'h0;
      rdata_q <= 32'h0;
      ae_q <= misal;
      be_q <= 1'b0;
      wen_q <= go_bus ? wen_n : 4'h0;
      addr_q <= go_bus ? {bus.req_addr[31:2], 2'b00} : 32'h0;
      wdata_q <= go_bus ? wdata_n : 32'h0;
    end else if (state == BUS) begin
      if (ack || tout) begin
        rdata_q <= ack ? ld_v : 32'h0;
        be_q <= tout;
        wen_q <= 4'h0;
        addr_q <= 32'h0;
        wdata_q <= 32'h0;
      end else cnt <= cnt + 8'd1;
    end
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = state == RESP ? rdata_q : 32'h0;
  assign bus.addr_err = state == RESP && ae_q;
  assign bus.bus_err = state == RESP && be_q;
  assign bus.mem_en = state == BUS;
  assign bus.mem_wen = wen_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
